uart_loader: RTL and testbench

- UART program loader: the host-side counterpart of the CPU's memory-mapped UART path.
- Receives a framed program image byte-by-byte from uart_rx and writes 16-bit words into instruction memory through a write port.
- Replies with a one-byte acknowledge through uart_tx.
- Holds the CPU in reset while a load is in progress; sits beside the CPU/ROM in top, on the 50 MHz UART clock domain.

---
 rtl/uart_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART program loader: receives a framed image from uart_rx, writes 16-bit
// words to instruction memory, replies with a one-byte acknowledge through
// uart_tx, and holds the CPU in reset while a frame is in flight.
module uart_loader #(
  parameter int unsigned          ADDR_W         = 16,
  parameter int unsigned          DEPTH          = 4096,
  parameter logic [ADDR_W-1:0]    BASE_ADDR      = '0,
  parameter logic [7:0]           SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]           ACK_OK         = 8'h4B,
  parameter logic [7:0]           ACK_ERR        = 8'h45,
  parameter int unsigned          TIMEOUT_CYCLES = 5000000
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_H,
    LEN_L,
    DATA_H,
    DATA_L,
    CSUM,
    RESP_START,
    RESP_WAIT
  } state_t;

  state_t      state;
  logic        rx_prev;
  logic [7:0]  hi_byte;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  sum;
  logic [31:0] tmo_cnt;
  logic        accept;
  logic        in_frame;
  logic        timeout_hit;

  // Byte strobe on rx_ready rising edge; frame states are the ones the timeout guards.
  always_comb begin
    accept      = rx_ready & ~rx_prev;
    in_frame    = (state == LEN_H) || (state == LEN_L) || (state == DATA_H) ||
                  (state == DATA_L) || (state == CSUM);
    timeout_hit = in_frame && !accept && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  end

  // Frame parser, memory write port, reply handshake and inter-byte timeout.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rx_prev  <= 1'b1;
      hi_byte  <= '0;
      len      <= '0;
      idx      <= '0;
      sum      <= '0;
      tmo_cnt  <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      mem_addr <= BASE_ADDR;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      rx_prev <= rx_ready;
      mem_we  <= 1'b0;

      if (in_frame) begin
        if (accept) tmo_cnt <= '0;
        else        tmo_cnt <= tmo_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (accept && rx_data == SYNC_BYTE) begin
            cpu_hold <= 1'b1;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
            sum      <= '0;
            idx      <= '0;
            tmo_cnt  <= '0;
            state    <= LEN_H;
          end
        end
        LEN_H: begin
          if (accept) begin
            len[15:8] <= rx_data;
            state     <= LEN_L;
          end
        end
        LEN_L: begin
          if (accept) begin
            len[7:0] <= rx_data;
            if (32'({len[15:8], rx_data}) > DEPTH) begin
              tx_data  <= ACK_ERR;
              tx_start <= 1'b1;
              state    <= RESP_START;
            end else if ({len[15:8], rx_data} == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA_H;
            end
          end
        end
        DATA_H: begin
          if (accept) begin
            hi_byte <= rx_data;
            sum     <= sum + rx_data;
            state   <= DATA_L;
          end
        end
        DATA_L: begin
          if (accept) begin
            mem_din  <= {hi_byte, rx_data};
            mem_addr <= BASE_ADDR + ADDR_W'(idx);
            mem_we   <= 1'b1;
            sum      <= sum + rx_data;
            idx      <= idx + 16'd1;
            if ((32'(idx) + 32'd1) < 32'(len)) state <= DATA_H;
            else                               state <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            tx_data  <= (rx_data == sum) ? ACK_OK : ACK_ERR;
            tx_start <= 1'b1;
            state    <= RESP_START;
          end
        end
        RESP_START: begin
          if (!tx_ready) begin
            tx_start <= 1'b0;
            state    <= RESP_WAIT;
          end
        end
        RESP_WAIT: begin
          if (tx_ready) begin
            load_ok  <= (tx_data == ACK_OK);
            load_err <= (tx_data != ACK_OK);
            cpu_hold <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Silence inside a frame abandons it without a reply; this overrides the case above.
      if (timeout_hit) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b0;
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader.
module tb_uart_loader;

  logic        clock;
  logic        n_rst;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_ok;
  logic        load_err;

  int checks = 0;
  int passed = 0;

  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          tx_cnt = 0;
  logic        tx_prev = 1'b0;

  uart_loader #(.TIMEOUT_CYCLES(1000)) dut (
    .clock    (clock),
    .n_rst    (n_rst),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .load_ok  (load_ok),
    .load_err (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every write strobe and every tx_start rising edge.
  always @(negedge clock) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
    end
    if (tx_start && !tx_prev) tx_cnt++;
    tx_prev = tx_start;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (2) @(negedge clock);
    rx_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Plays the uart_tx side of one acknowledge; reports what it saw.
  task automatic serve_tx(output logic got, output logic [7:0] data, output logic hold);
    for (int i = 0; i < 50 && !tx_start; i++) @(negedge clock);
    got  = tx_start;
    data = tx_data;
    hold = 1'b0;
    if (got) begin
      repeat (2) @(negedge clock);
      tx_ready = 1'b0;
      for (int i = 0; i < 10 && tx_start; i++) @(negedge clock);
      repeat (8) @(negedge clock);
      hold     = cpu_hold;
      tx_ready = 1'b1;
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic test_reset;
    n_rst    = 1'b0;
    rx_ready = 1'b1;
    rx_data  = 8'hA5;
    tx_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx_start, tx_data, mem_addr, mem_din, mem_we, cpu_hold, load_ok, load_err} !== 45'd0)
      $display("FAIL reset_values: got %h want 0",
               {tx_start, tx_data, mem_addr, mem_din, mem_we, cpu_hold, load_ok, load_err});
    else passed++;
    n_rst = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (cpu_hold !== 1'b0) $display("FAIL held_rx_ready: cpu_hold got %b want 0", cpu_hold);
    else passed++;
    rx_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_good_frame;
    // CSUM = 12+34+AB+CD = 0x1BE -> 0xBE
    logic [7:0] f[7] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    int base = wa_q.size();
    int tb0  = tx_cnt;
    logic got, hold;
    logic [7:0] d;
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++;
    if (cpu_hold !== 1'b0) $display("FAIL garbage_ignored: cpu_hold got %b want 0", cpu_hold);
    else passed++;
    foreach (f[i]) send_byte(f[i]);
    checks++;
    if (cpu_hold !== 1'b1) $display("FAIL hold_in_frame: cpu_hold got %b want 1", cpu_hold);
    else passed++;
    send_byte(8'hBE);
    checks++;
    if (wa_q.size() - base !== 2) $display("FAIL good_wr_count: got %0d want 2", wa_q.size() - base);
    else passed++;
    checks++;
    if ({wa_q[base], wd_q[base]} !== 32'h0000_1234)
      $display("FAIL good_word0: got %h want 00001234", {wa_q[base], wd_q[base]});
    else passed++;
    checks++;
    if ({wa_q[base+1], wd_q[base+1]} !== 32'h0001_ABCD)
      $display("FAIL good_word1: got %h want 0001abcd", {wa_q[base+1], wd_q[base+1]});
    else passed++;
    serve_tx(got, d, hold);
    checks++;
    if (got !== 1'b1) $display("FAIL good_tx_start: got %b want 1", got);
    else passed++;
    checks++;
    if (d !== 8'h4B) $display("FAIL good_reply: got %h want 4b", d);
    else passed++;
    checks++;
    if (hold !== 1'b1) $display("FAIL hold_during_ack: got %b want 1", hold);
    else passed++;
    checks++;
    if ({cpu_hold, load_ok, load_err} !== 3'b010)
      $display("FAIL good_flags: hold/ok/err got %b want 010", {cpu_hold, load_ok, load_err});
    else passed++;
    checks++;
    if (tx_cnt - tb0 !== 1) $display("FAIL good_tx_count: got %0d want 1", tx_cnt - tb0);
    else passed++;
  endtask

  task automatic test_bad_csum;
    logic [7:0] f[8] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
    int base = wa_q.size();
    logic got, hold;
    logic [7:0] d;
    foreach (f[i]) send_byte(f[i]);
    checks++;
    if (wa_q.size() - base !== 2) $display("FAIL bad_wr_count: got %0d want 2", wa_q.size() - base);
    else passed++;
    serve_tx(got, d, hold);
    checks++;
    if ({got, d} !== 9'h145) $display("FAIL bad_reply: got %h want 145", {got, d});
    else passed++;
    checks++;
    if ({cpu_hold, load_ok, load_err} !== 3'b001)
      $display("FAIL bad_flags: hold/ok/err got %b want 001", {cpu_hold, load_ok, load_err});
    else passed++;
  endtask

  task automatic test_zero_len;
    logic [7:0] f[4] = '{8'hA5, 8'h00, 8'h00, 8'h00};
    int base = wa_q.size();
    logic got, hold;
    logic [7:0] d;
    foreach (f[i]) send_byte(f[i]);
    serve_tx(got, d, hold);
    checks++;
    if (wa_q.size() - base !== 0) $display("FAIL zero_wr_count: got %0d want 0", wa_q.size() - base);
    else passed++;
    checks++;
    if ({got, d} !== 9'h14B) $display("FAIL zero_reply: got %h want 14b", {got, d});
    else passed++;
    checks++;
    if ({cpu_hold, load_ok, load_err} !== 3'b010)
      $display("FAIL zero_flags: hold/ok/err got %b want 010", {cpu_hold, load_ok, load_err});
    else passed++;
  endtask

  task automatic test_too_long;
    logic [7:0] f[3] = '{8'hA5, 8'h10, 8'h01};
    int base = wa_q.size();
    logic got, hold;
    logic [7:0] d;
    foreach (f[i]) send_byte(f[i]);
    serve_tx(got, d, hold);
    checks++;
    if (wa_q.size() - base !== 0) $display("FAIL long_wr_count: got %0d want 0", wa_q.size() - base);
    else passed++;
    checks++;
    if ({got, d} !== 9'h145) $display("FAIL long_reply: got %h want 145", {got, d});
    else passed++;
    checks++;
    if ({cpu_hold, load_ok, load_err} !== 3'b001)
      $display("FAIL long_flags: hold/ok/err got %b want 001", {cpu_hold, load_ok, load_err});
    else passed++;
  endtask

  task automatic test_timeout;
    logic [7:0] f[5] = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    int base = wa_q.size();
    int tb0  = tx_cnt;
    foreach (f[i]) send_byte(f[i]);
    repeat (1100) @(negedge clock);
    checks++;
    if (wa_q.size() - base !== 1) $display("FAIL tmo_wr_count: got %0d want 1", wa_q.size() - base);
    else passed++;
    checks++;
    if ({wa_q[base], wd_q[base]} !== 32'h0000_1122)
      $display("FAIL tmo_word0: got %h want 00001122", {wa_q[base], wd_q[base]});
    else passed++;
    checks++;
    if (tx_cnt - tb0 !== 0) $display("FAIL tmo_no_reply: got %0d want 0", tx_cnt - tb0);
    else passed++;
    checks++;
    if ({cpu_hold, load_ok, load_err} !== 3'b001)
      $display("FAIL tmo_flags: hold/ok/err got %b want 001", {cpu_hold, load_ok, load_err});
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] f[8] = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h99};
    logic [7:0] z[4] = '{8'hA5, 8'h00, 8'h00, 8'h00};
    int base;
    foreach (f[i]) send_byte(f[i]);
    checks++;
    if ({cpu_hold, mem_addr, mem_din} !== 33'h1_0001_5678)
      $display("FAIL mid_before: got %h want 100015678", {cpu_hold, mem_addr, mem_din});
    else passed++;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, mem_addr, mem_din, mem_we, cpu_hold, load_ok, load_err} !== 45'd0)
      $display("FAIL mid_async_reset: got %h want 0",
               {tx_start, tx_data, mem_addr, mem_din, mem_we, cpu_hold, load_ok, load_err});
    else passed++;
    @(negedge clock);
    n_rst = 1'b1;
    base  = wa_q.size();
    send_byte(8'h34);
    send_byte(8'h56);
    checks++;
    if ({cpu_hold, 8'(wa_q.size() - base)} !== 9'h000)
      $display("FAIL mid_back_idle: hold/writes got %h want 000", {cpu_hold, 8'(wa_q.size() - base)});
    else passed++;
    // Reset while an acknowledge is being requested drops tx_start at once.
    foreach (z[i]) send_byte(z[i]);
    for (int i = 0; i < 50 && !tx_start; i++) @(negedge clock);
    checks++;
    if (tx_start !== 1'b1) $display("FAIL ack_req: tx_start got %b want 1", tx_start);
    else passed++;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, cpu_hold} !== 10'd0)
      $display("FAIL ack_reset: got %h want 0", {tx_start, tx_data, cpu_hold});
    else passed++;
    @(negedge clock);
    n_rst = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len();
    test_too_long();
    test_timeout();
    test_good_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
